// File: rtl/call_stack.sv
// Return-address stack: top is combinational from the array, and push/pop/state updates take 1 cycle.
// There is no backpressure; a push when full or a pop when empty sets a sticky ovf/unf flag. Optional Z-flag save: CALL_STACK_ZSAVE_EN.
module call_stack #(
  parameter int AW    = 10,
  parameter int DEPTH = 8,
  localparam int IW   = $clog2(DEPTH),
  localparam int SPW  = $clog2(DEPTH) + 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic [AW-1:0]  ret_i,
  input  logic           clr_err_i,
`ifdef CALL_STACK_ZSAVE_EN
  input  logic           z_i,
  output logic           z_top_o,
`endif
  output logic [AW-1:0]  top_o,
  output logic [SPW-1:0] count_o,
  output logic           empty_o,
  output logic           full_o,
  output logic           ovf_o,
  output logic           unf_o
);

  logic [SPW-1:0] sp_q, sp_d, sp_m1;
  logic           ovf_q, ovf_d, unf_q, unf_d;
  logic           wr_en;
  logic [IW-1:0]  wr_idx;
  logic [AW-1:0]  mem_q [DEPTH];
  logic           empty, full;

  assign empty = (sp_q == '0);
  assign full  = (sp_q == SPW'(DEPTH));
  assign sp_m1 = sp_q - SPW'(1);

  always_comb begin
    sp_d   = sp_q;
    ovf_d  = ovf_q & ~clr_err_i;
    unf_d  = unf_q & ~clr_err_i;
    wr_en  = 1'b0;
    wr_idx = sp_q[IW-1:0];
    if (push_i && pop_i) begin
      wr_en = 1'b1;
      if (empty) begin
        wr_idx = '0;
        sp_d   = SPW'(1);
      end else begin
        // Tail-call replace: overwrite the top entry in place, legal even when full.
        wr_idx = sp_m1[IW-1:0];
      end
    end else if (push_i) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        sp_d  = sp_q + SPW'(1);
      end
    end else if (pop_i) begin
      if (empty) unf_d = 1'b1;
      else       sp_d  = sp_m1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Array is deliberately unreset; stale entries are hidden by the empty mask on top.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_idx] <= ret_i;
  end

  assign top_o   = empty ? '0 : mem_q[sp_m1[IW-1:0]];
  assign count_o = sp_q;
  assign empty_o = empty;
  assign full_o  = full;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

`ifdef CALL_STACK_ZSAVE_EN
  logic z_mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en) z_mem_q[wr_idx] <= z_i;
  end

  assign z_top_o = empty ? 1'b0 : z_mem_q[sp_m1[IW-1:0]];
`endif

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack with hand-computed expectations.
module tb_call_stack;
  localparam int AW    = 10;
  localparam int DEPTH = 8;
  localparam int SPW   = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           push = 1'b0, pop = 1'b0, clr = 1'b0;
  logic [AW-1:0]  ret = '0;
  logic [AW-1:0]  top;
  logic [SPW-1:0] count;
  logic           empty, full, ovf, unf;
`ifdef CALL_STACK_ZSAVE_EN
  logic           z_in = 1'b0;
  logic           z_top;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  call_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .push_i    (push),
    .pop_i     (pop),
    .ret_i     (ret),
    .clr_err_i (clr),
`ifdef CALL_STACK_ZSAVE_EN
    .z_i       (z_in),
    .z_top_o   (z_top),
`endif
    .top_o     (top),
    .count_o   (count),
    .empty_o   (empty),
    .full_o    (full),
    .ovf_o     (ovf),
    .unf_o     (unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one edge with the currently driven inputs, then return to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr = 1'b0;
  endtask

  task automatic do_push(input logic [AW-1:0] v);
    push = 1'b1; ret = v;
    tick();
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full),  0);
    chk("rst_ovf",   32'(ovf),   0);
    chk("rst_unf",   32'(unf),   0);
    chk("rst_top",   32'(top),   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic LIFO order, top read on the pop cycle itself
    do_push(10'h010);
    chk("push1_top", 32'(top), 32'h010);
    do_push(10'h020);
    do_push(10'h030);
    chk("push3_count", 32'(count), 3);
    chk("push3_top",   32'(top),   32'h030);
    push = 1'b1; ret = 10'h3AA;
    #1;
    chk("no_comb_count", 32'(count), 3);
    chk("no_comb_top",   32'(top),   32'h030);
    push = 1'b0;
    pop = 1'b1; #1;
    chk("pop1_top", 32'(top), 32'h030);
    tick();
    pop = 1'b1; #1;
    chk("pop2_top", 32'(top), 32'h020);
    tick();
    pop = 1'b1; #1;
    chk("pop3_top", 32'(top), 32'h010);
    tick();
    chk("drain_empty", 32'(empty), 1);
    chk("drain_top",   32'(top),   0);
    chk("drain_count", 32'(count), 0);

    // Fill to DEPTH, then overflow
    for (int i = 0; i < DEPTH; i++) do_push(AW'(10'h100 + i));
    chk("fill_full",  32'(full),  1);
    chk("fill_count", 32'(count), 8);
    chk("fill_top",   32'(top),   32'h107);
    do_push(10'h3FF);
    chk("ovf_set",   32'(ovf),   1);
    chk("ovf_count", 32'(count), 8);
    chk("ovf_top",   32'(top),   32'h107);
    // Replace while full is legal and raises no error
    clr = 1'b1; tick();
    chk("ovf_clr", 32'(ovf), 0);
    push = 1'b1; pop = 1'b1; ret = 10'h2B2;
    tick();
    chk("repl_full_top",   32'(top),   32'h2B2);
    chk("repl_full_count", 32'(count), 8);
    chk("repl_full_ovf",   32'(ovf),   0);
    for (int i = 0; i < DEPTH; i++) do_pop();
    chk("empty_again", 32'(empty), 1);

    // Underflow, set wins over clear
    do_pop();
    chk("unf_set",   32'(unf),   1);
    chk("unf_count", 32'(count), 0);
    pop = 1'b1; clr = 1'b1;
    tick();
    chk("unf_set_wins", 32'(unf), 1);
    clr = 1'b1; tick();
    chk("unf_clr", 32'(unf), 0);

    // Simultaneous push+pop
    do_push(10'h005);
    do_push(10'h006);
    push = 1'b1; pop = 1'b1; ret = 10'h100;
    tick();
    chk("repl_count", 32'(count), 2);
    chk("repl_top",   32'(top),   32'h100);
    do_pop();
    chk("repl_pop_top", 32'(top), 32'h005);
    do_pop();
    push = 1'b1; pop = 1'b1; ret = 10'h055;
    tick();
    chk("pp_empty_count", 32'(count), 1);
    chk("pp_empty_top",   32'(top),   32'h055);
    chk("pp_empty_unf",   32'(unf),   0);
    do_pop();

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) do_push(AW'(10'h200 + i));
    chk("pre_rst_count", 32'(count), 5);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_top",   32'(top),   0);
    #1 rst_n = 1'b1;
    do_push(10'h001);
    chk("post_rst_top",   32'(top),   32'h001);
    chk("post_rst_count", 32'(count), 1);
    do_pop();

`ifdef CALL_STACK_ZSAVE_EN
    chk("z_empty", 32'(z_top), 0);
    z_in = 1'b1; do_push(10'h040);
    z_in = 1'b0; do_push(10'h041);
    chk("z_top0", 32'(z_top), 0);
    do_pop();
    chk("z_pop_top", 32'(top),   32'h040);
    chk("z_pop_z",   32'(z_top), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
